// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types for the load/store front-end (mem_access_unit).
//   size_e   : access size encoding as carried on req_size
//   state_e  : control FSM states of mem_access_unit
//   wr_mask  : per-byte-lane write enables for a store of a given size
// Lane k of the data memory holds address+k, so the write mask is always
// right-aligned and never depends on the low address bits.
// ---------------------------------------------------------------------------
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_BAD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD_WAIT,
      RESP
   } state_e;

   // Largest memory read latency the wait counter is sized for.
   localparam int MAX_READ_LATENCY = 4;

   // Byte lanes written by a store; an illegal size writes nothing.
   function automatic logic [3:0] wr_mask(input size_e size);
      logic [3:0] mask;
      case (size)
         SZ_B:    mask = 4'b0001;
         SZ_H:    mask = 4'b0011;
         SZ_W:    mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the request, response and data-memory signals of mem_access_unit.
//   req_*        : CPU request channel (valid/ready)
//   rsp_*        : response channel back to the CPU (valid/ready)
//   mem_*        : 4-bank byte-lane data memory port
// Modports:
//   slave  : the access unit's view (accepts requests, drives the memory)
//   master : the environment's view (CPU datapath plus memory)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] mem_raddress;
   logic [31:0] mem_waddress;
   logic [31:0] mem_datain;
   logic [3:0]  mem_wr;
   logic [31:0] mem_dataout;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_ready, mem_dataout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_raddress, mem_waddress, mem_datain, mem_wr
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_ready, mem_dataout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_raddress, mem_waddress, mem_datain, mem_wr
   );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of a load result.
//   data       in  32  raw word from the memory (lane k = address+k)
//   size       in  2   access size (byte / half / word)
//   isUnsigned in  1   1 = zero-extend, 0 = sign-extend
//   ext        out 32  extended result
// ---------------------------------------------------------------------------
module load_extend
   import mem_access_pkg::*;
(
   input  logic [31:0] data,
   input  size_e       size,
   input  logic        isUnsigned,
   output logic [31:0] ext
);

   // Bytes and halves take their fill bit from their own top bit unless the
   // load is unsigned; words (and the never-used illegal size) pass through.
   always_comb begin
      ext = data;
      case (size)
         SZ_B:    ext = {{24{~isUnsigned & data[7]}}, data[7:0]};
         SZ_H:    ext = {{16{~isUnsigned & data[15]}}, data[15:0]};
         default: ext = data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store front-end between the CPU datapath and the 4-bank byte-lane
// data memory. One request at a time; every request gets one response.
// Ports:
//   Clk    in  clock, rising edge
//   Reset  in  asynchronous, active-high reset
//   bus    mem_access_unit_if.slave (request, response and memory signals)
// Parameter:
//   READ_LATENCY  memory read latency in cycles, address cycle excluded (1..4)
// Optional feature:
//   MEM_ACCESS_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses
//   are rejected with rsp_err and never touch the memory.
// All outputs are registered except req_ready, which is state==IDLE.
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int READ_LATENCY = 1
) (
   input logic             Clk,
   input logic             Reset,
   mem_access_unit_if.slave bus
);
   import mem_access_pkg::*;

   localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY);

   state_e      state;
   state_e      nextState;
   logic [2:0]  waitCnt;
   size_e       reqSize;
   logic        reqUnsigned;
   size_e       inSize;
   logic        misaligned;
   logic        badReq;
   logic        accept;
   logic        lastWait;
   logic [31:0] extData;

   assign inSize   = size_e'(bus.req_size);
   assign accept   = (state == IDLE) && bus.req_valid;
   assign lastWait = (waitCnt == LAST_WAIT);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misaligned = ((inSize == SZ_H) && bus.req_addr[0]) ||
                       ((inSize == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign badReq        = (inSize == SZ_BAD) || misaligned;
   assign bus.req_ready = (state == IDLE);

   load_extend extendUnit (
      .data       (bus.mem_dataout),
      .size       (reqSize),
      .isUnsigned (reqUnsigned),
      .ext        (extData)
   );

   // State register: reset always lands in IDLE, abandoning any access.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: rejected requests skip straight to RESP, stores spend
   // one cycle in WR, loads wait READ_LATENCY+1 cycles in RD_WAIT, and RESP
   // holds until the consumer takes the response.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (badReq) begin
                  nextState = RESP;
               end else if (bus.req_write) begin
                  nextState = WR;
               end else begin
                  nextState = RD_WAIT;
               end
            end
         end
         WR:      nextState = RESP;
         RD_WAIT: if (lastWait) nextState = RESP;
         RESP:    if (bus.rsp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Registered datapath and outputs. mem_wr defaults to zero every cycle so
   // it can only be high in the single WR cycle, and the async reset clears
   // it immediately if a store is interrupted. Request fields are captured
   // on the accept edge; the load result is captured on the edge ending the
   // last RD_WAIT cycle. rsp_rdata is cleared at accept so stores and
   // rejected requests answer with zero.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bus.rsp_valid    <= 1'b0;
         bus.rsp_err      <= 1'b0;
         bus.rsp_rdata    <= '0;
         bus.mem_raddress <= '0;
         bus.mem_waddress <= '0;
         bus.mem_datain   <= '0;
         bus.mem_wr       <= 4'b0000;
         waitCnt          <= '0;
         reqSize          <= SZ_B;
         reqUnsigned      <= 1'b0;
      end else begin
         bus.mem_wr    <= 4'b0000;
         bus.rsp_valid <= (nextState == RESP);
         if (accept) begin
            reqSize       <= inSize;
            reqUnsigned   <= bus.req_unsigned;
            bus.rsp_err   <= badReq;
            bus.rsp_rdata <= '0;
            waitCnt       <= '0;
            if (!badReq && bus.req_write) begin
               bus.mem_waddress <= bus.req_addr;
               bus.mem_datain   <= bus.req_wdata;
               bus.mem_wr       <= wr_mask(inSize);
            end
            if (!badReq && !bus.req_write) begin
               bus.mem_raddress <= bus.req_addr;
            end
         end
         if (state == RD_WAIT) begin
            waitCnt <= waitCnt + 3'd1;
            if (lastWait) begin
               bus.rsp_rdata <= extData;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. Instance dutA uses READ_LATENCY=1
// and is attached to a byte-lane memory model; dutB uses READ_LATENCY=3 and
// reads the same memory through a three-stage pipeline. Memory byte at
// address a initially holds a[7:0] ^ a[15:8] ^ 8'hA5.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   typedef struct {
      logic        write;
      logic [1:0]  size;
      logic        isUnsigned;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLatency;
      logic [3:0]  expMask;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   int   wrCount = 0;
   logic [3:0] lastMask = 4'b0000;

   logic [7:0]        memBytes [0:65535];
   logic [31:0]       pipeA;
   logic [2:0][31:0]  pipeB;

   vec_t vecs [15];

   mem_access_unit_if busA ();
   mem_access_unit_if busB ();

   mem_access_unit #(.READ_LATENCY(1)) dutA (.Clk(Clk), .Reset(Reset), .bus(busA));
   mem_access_unit #(.READ_LATENCY(3)) dutB (.Clk(Clk), .Reset(Reset), .bus(busB));

   // Free-running 10-unit clock.
   always #5 Clk = ~Clk;

   // Preload the memory with an address-derived pattern.
   initial begin
      for (int i = 0; i < 65536; i++) begin
         memBytes[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
      end
   end

   // Memory writes happen mid-cycle on whatever lanes dutA enables; the
   // monitor also counts every cycle in which a write enable is seen.
   always @(negedge Clk) begin
      if (busA.mem_wr != 4'b0000) begin
         wrCount++;
         lastMask = busA.mem_wr;
      end
      for (int k = 0; k < 4; k++) begin
         if (busA.mem_wr[k]) begin
            memBytes[busA.mem_waddress[15:0] + 16'(k)] = busA.mem_datain[8*k +: 8];
         end
      end
   end

   function automatic logic [31:0] readWord(input logic [31:0] a);
      logic [15:0] b;
      b = a[15:0];
      return {memBytes[b + 16'd3], memBytes[b + 16'd2], memBytes[b + 16'd1], memBytes[b]};
   endfunction

   // Read pipelines: one register for dutA, three for dutB.
   always @(posedge Clk) begin
      pipeA <= readWord(busA.mem_raddress);
      pipeB <= {pipeB[1:0], readWord(busB.mem_raddress)};
   end

   assign busA.mem_dataout = pipeA;
   assign busB.mem_dataout = pipeB[2];

   // Hard time limit so the bench always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   function automatic vec_t mkVec(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] er, input logic ee,
                                  input int el, input logic [3:0] em);
      vec_t v;
      v.write = w; v.size = sz; v.isUnsigned = u; v.addr = a; v.wdata = wd;
      v.expRdata = er; v.expErr = ee; v.expLatency = el; v.expMask = em;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Runs one transaction on dutA with rsp_ready high and reports the
   // response cycle (1 = cycle after accept), data, error and write pulses.
   task automatic applyStimulus(input vec_t v, output int latency,
                                output logic [31:0] rdata, output logic err,
                                output int pulses, output logic [3:0] mask);
      int startWr;
      latency = -1;
      rdata   = '0;
      err     = 1'b0;
      @(negedge Clk);
      busA.req_valid    = 1'b1;
      busA.req_write    = v.write;
      busA.req_size     = v.size;
      busA.req_unsigned = v.isUnsigned;
      busA.req_addr     = v.addr;
      busA.req_wdata    = v.wdata;
      busA.rsp_ready    = 1'b1;
      startWr           = wrCount;
      @(posedge Clk);
      #1;
      busA.req_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge Clk);
         if (busA.rsp_valid) begin
            latency = n;
            rdata   = busA.rsp_rdata;
            err     = busA.rsp_err;
            break;
         end
      end
      @(posedge Clk);
      #1;
      pulses = wrCount - startWr;
      mask   = lastMask;
   endtask

   initial begin
      int          lat;
      int          pulses;
      int          expPulses;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  mask;
      int          startWr;

      vecs[0]  = mkVec(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 4'b1111);
      vecs[1]  = mkVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 4'b0000);
      vecs[2]  = mkVec(1'b1, 2'b00, 1'b0, 32'h21, 32'h12345680, 32'h0, 1'b0, 2, 4'b0001);
      vecs[3]  = mkVec(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 3, 4'b0000);
      vecs[4]  = mkVec(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0, 3, 4'b0000);
      vecs[5]  = mkVec(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h86878085, 1'b0, 3, 4'b0000);
      vecs[6]  = mkVec(1'b1, 2'b10, 1'b0, 32'h30, 32'h12348765, 32'h0, 1'b0, 2, 4'b1111);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      vecs[7]  = mkVec(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, 32'h0, 1'b1, 1, 4'b0000);
      vecs[11] = mkVec(1'b0, 2'b10, 1'b0, 32'hFFFF, 32'h0, 32'h0, 1'b1, 1, 4'b0000);
`else
      vecs[7]  = mkVec(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, 32'h00003487, 1'b0, 3, 4'b0000);
      vecs[11] = mkVec(1'b0, 2'b10, 1'b0, 32'hFFFF, 32'h0, 32'hA7A4A5A5, 1'b0, 3, 4'b0000);
`endif
      vecs[8]  = mkVec(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFF8765, 1'b0, 3, 4'b0000);
      vecs[9]  = mkVec(1'b1, 2'b01, 1'b0, 32'h50, 32'h0000ABCD, 32'h0, 1'b0, 2, 4'b0011);
      vecs[10] = mkVec(1'b0, 2'b01, 1'b0, 32'h50, 32'h0, 32'hFFFFABCD, 1'b0, 3, 4'b0000);
      vecs[12] = mkVec(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 4'b0000);
      vecs[13] = mkVec(1'b1, 2'b11, 1'b0, 32'h60, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 4'b0000);
      vecs[14] = mkVec(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'hC6C7C4C5, 1'b0, 3, 4'b0000);

      Reset = 1'b1;
      busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_size = 2'b00;
      busA.req_unsigned = 1'b0; busA.req_addr = '0; busA.req_wdata = '0;
      busA.rsp_ready = 1'b1;
      busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_size = 2'b00;
      busB.req_unsigned = 1'b0; busB.req_addr = '0; busB.req_wdata = '0;
      busB.rsp_ready = 1'b1;
      #12;
      checkOutput("reset req_ready", 32'(busA.req_ready), 32'h1);
      checkOutput("reset rsp_valid", 32'(busA.rsp_valid), 32'h0);
      checkOutput("reset rsp_err", 32'(busA.rsp_err), 32'h0);
      checkOutput("reset rsp_rdata", busA.rsp_rdata, 32'h0);
      checkOutput("reset mem_wr", 32'(busA.mem_wr), 32'h0);
      checkOutput("reset mem_raddress", busA.mem_raddress, 32'h0);
      checkOutput("reset mem_waddress", busA.mem_waddress, 32'h0);
      checkOutput("reset mem_datain", busA.mem_datain, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;

      $display("[TB] table vectors");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i], lat, rdata, err, pulses, mask);
         expPulses = (vecs[i].write && !vecs[i].expErr) ? 1 : 0;
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLatency));
         checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d wr pulses", i), 32'(pulses), 32'(expPulses));
         if (expPulses == 1) begin
            checkOutput($sformatf("vec%0d wr mask", i), 32'(mask), 32'(vecs[i].expMask));
         end
      end

      $display("[TB] response back-pressure");
      @(negedge Clk);
      busA.req_valid = 1'b1; busA.req_write = 1'b0; busA.req_size = 2'b10;
      busA.req_unsigned = 1'b0; busA.req_addr = 32'h10; busA.rsp_ready = 1'b0;
      @(posedge Clk);
      #1;
      busA.req_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge Clk);
         if (busA.rsp_valid) begin
            lat = n;
            break;
         end
      end
      checkOutput("hold latency", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         checkOutput($sformatf("hold%0d rsp_valid", c), 32'(busA.rsp_valid), 32'h1);
         checkOutput($sformatf("hold%0d rsp_rdata", c), busA.rsp_rdata, 32'hDEADBEEF);
         checkOutput($sformatf("hold%0d req_ready", c), 32'(busA.req_ready), 32'h0);
      end
      busA.rsp_ready = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("release rsp_valid", 32'(busA.rsp_valid), 32'h0);
      checkOutput("release req_ready", 32'(busA.req_ready), 32'h1);

      $display("[TB] reset during store");
      startWr = wrCount;
      @(negedge Clk);
      busA.req_valid = 1'b1; busA.req_write = 1'b1; busA.req_size = 2'b10;
      busA.req_addr = 32'h40; busA.req_wdata = 32'h11223344;
      @(posedge Clk);
      #1;
      busA.req_valid = 1'b0;
      checkOutput("wr-state mem_wr", 32'(busA.mem_wr), 32'hF);
      #1;
      Reset = 1'b1;
      #1;
      checkOutput("reset-in-wr mem_wr", 32'(busA.mem_wr), 32'h0);
      checkOutput("reset-in-wr req_ready", 32'(busA.req_ready), 32'h1);
      @(negedge Clk);
      checkOutput("reset-in-wr pulses", 32'(wrCount - startWr), 32'h0);
      Reset = 1'b0;
      applyStimulus(mkVec(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 3, 4'b0),
                    lat, rdata, err, pulses, mask);
      checkOutput("after-reset load rdata", rdata, 32'hE6E7E4E5);
      checkOutput("after-reset load latency", 32'(lat), 32'd3);

      $display("[TB] READ_LATENCY=3 instance");
      @(negedge Clk);
      busB.req_valid = 1'b1; busB.req_write = 1'b0; busB.req_size = 2'b10;
      busB.req_unsigned = 1'b0; busB.req_addr = 32'h10;
      @(posedge Clk);
      #1;
      busB.req_valid = 1'b0;
      lat = -1;
      rdata = '0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge Clk);
         if (busB.rsp_valid) begin
            lat = n;
            rdata = busB.rsp_rdata;
            break;
         end
      end
      checkOutput("rl3 latency", 32'(lat), 32'd5);
      checkOutput("rl3 rdata", rdata, 32'hDEADBEEF);
      @(posedge Clk);
      #1;
      checkOutput("rl3 req_ready", 32'(busB.req_ready), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
